// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
//   DEFAULT_WIDTH : default payload width in bits
//   DEFAULT_DEPTH : default number of register stages
//   occ_width()   : bit width needed to count 0..depth valid stages
package pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH = 2;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One stage of the elastic pipeline: a data register, a valid bit and the
// local ready term. The stage loads whenever it is empty or its downstream
// neighbour can take its current item, so bubbles collapse.
//   clk, reset_n        : clock, asynchronous active-low reset
//   flush               : synchronous clear of the valid bit (data holds)
//   up_valid, up_data   : item offered by the upstream neighbour
//   down_ready          : downstream neighbour can accept this stage's item
//   valid, data         : registered stage contents
//   ready               : this stage can accept an item this cycle
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = !valid || down_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_DATA;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline of DEPTH register stages. Stage 0 faces the
// input, stage DEPTH-1 drives the output. The ready chain runs
// combinationally from out_ready back to in_ready; everything else on the
// output side comes straight from registers.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : discard all in-flight items at the next edge
//   in_valid/in_ready     : upstream handshake, in_data payload
//   out_valid/out_ready   : downstream handshake, out_data payload
//   occupancy             : number of valid stages (0..DEPTH)
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned      DEPTH      = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH:0]   ready_chain;
  logic [WIDTH-1:0] stage_data [DEPTH];

  assign ready_chain[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = valid_vec[k-1];
      assign up_data  = stage_data[k-1];
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (ready_chain[k+1]),
      .valid      (valid_vec[k]),
      .data       (stage_data[k]),
      .ready      (ready_chain[k])
    );
  end

  // reset_n gates in_ready so nothing appears acceptable while held in reset,
  // even though the emptied stages would otherwise report ready.
  assign in_ready  = ready_chain[0] && !flush && reset_n;
  assign out_valid = valid_vec[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_vec[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
module tb_pipe_reg_elastic;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] occupancy;

  int vectors;
  int miscompares;
  logic [3:0] exp_q [$];

  pipe_reg_elastic #(
    .WIDTH      (4),
    .DEPTH      (3),
    .RESET_DATA (4'hE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one item for one cycle; exp_rdy is the hand-derived acceptance.
  task automatic push(input logic [3:0] d, input logic exp_rdy);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    check("in_ready_on_push", in_ready, exp_rdy);
    if (exp_rdy) exp_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled output holds still.
  initial begin
    logic       prev_stall;
    logic       prev_flush;
    logic [3:0] prev_data;
    logic [3:0] e;
    prev_stall = 1'b0;
    prev_flush = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (prev_stall && !prev_flush) begin
          check("stall_hold_valid", out_valid, 1);
          check("stall_hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          check("out_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_flush = flush;
      end else begin
        prev_stall = 1'b0;
        prev_flush = 1'b0;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 4'hE);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Streaming 1..4 with out_ready high; first output two edges after
    // the accepting edge, i.e. on the third edge counting acceptance.
    out_ready = 1'b1;
    push(4'h1, 1'b1);
    push(4'h2, 1'b1);
    check("lat_not_early", out_valid, 0);
    push(4'h3, 1'b1);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_data", out_data, 4'h1);
    check("occ_peak", occupancy, 3);
    push(4'h4, 1'b1);
    drain(10);

    // Backpressure: fill 5,6,7 while stalled
    out_ready = 1'b0;
    push(4'h5, 1'b1);
    push(4'h6, 1'b1);
    push(4'h7, 1'b1);
    check("bp_occupancy", occupancy, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 4'h5);
    repeat (2) @(posedge clk);
    #1;
    check("bp_still_5", out_data, 4'h5);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    drain(10);

    // Bubble collapse: 9 then A, B accepted without stall
    out_ready = 1'b0;
    push(4'h9, 1'b1);
    check("bub_occupancy1", occupancy, 1);
    push(4'hA, 1'b1);
    push(4'hB, 1'b1);
    check("bub_occupancy3", occupancy, 3);
    out_ready = 1'b1;
    drain(10);

    // Flush with the pipe full and an offer of C
    out_ready = 1'b0;
    push(4'h3, 1'b1);
    push(4'h4, 1'b1);
    push(4'h5, 1'b1);
    check("fl_pre_occupancy", occupancy, 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'hC;
    #1;
    check("fl_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("fl_occupancy", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("fl_still_empty", occupancy, 0);

    // Asynchronous reset mid-operation with two items in flight
    out_ready = 1'b0;
    push(4'h6, 1'b1);
    push(4'h7, 1'b1);
    check("ar_pre_occupancy", occupancy, 2);
    #1;
    reset_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_occupancy", occupancy, 0);
    check("ar_out_data", out_data, 4'hE);
    check("ar_in_ready", in_ready, 0);
    exp_q.delete();
    reset_n = 1'b1;
    out_ready = 1'b1;
    push(4'hD, 1'b1);
    drain(10);

    repeat (3) @(posedge clk);
    #1;
    check("final_empty", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
